// File: rtl/sevenseg_hexdec_decoder.sv
// Registered 4-bit decoder: one hex glyph on discrete segments a..g, plus a
// two-digit decimal rendering (tens/units) of the same value on 8-bit buses.
module sevenseg_hexdec_decoder #(
  parameter int BLANK_LEADING_ZERO = 1,
  parameter int ACTIVE_LOW         = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic [7:0] segh,
  output logic [7:0] segl
);

  localparam logic [6:0] GLYPH_BLANK = 7'h00;
  localparam logic [6:0] GLYPH_ONE   = 7'h06;
  localparam logic [6:0] GLYPH_ZERO  = 7'h3F;

  // Polarity mask covers every segment bit including dp, so reset and decode
  // share one inversion point.
  localparam logic [6:0] HEX_MASK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [7:0] BUS_MASK = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  // Active-high glyph, bit6 = g down to bit0 = a.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Splits 0..15 into tens (0/1) and units (0..9); returns {tens, units}.
  function automatic logic [4:0] dec_split(input logic [3:0] code);
    logic       tens;
    logic [3:0] units;
    tens  = (code >= 4'd10);
    units = tens ? (code - 4'd10) : code;
    return {tens, units};
  endfunction

  function automatic logic [7:0] tens_bus(input logic tens);
    logic [6:0] seg;
    if (tens)
      seg = GLYPH_ONE;
    else if (BLANK_LEADING_ZERO != 0)
      seg = GLYPH_BLANK;
    else
      seg = GLYPH_ZERO;
    return {1'b0, seg};
  endfunction

  logic [3:0] v_p0;
  logic [4:0] split_p0;
  logic [6:0] hex_p0;
  logic [7:0] segh_p0;
  logic [7:0] segl_p0;

  // Stage p0: combinational decode of the input code.
  always_comb begin
    v_p0     = {A, B, C, D};
    split_p0 = dec_split(v_p0);
    hex_p0   = glyph(v_p0) ^ HEX_MASK;
    segh_p0  = tens_bus(split_p0[4]) ^ BUS_MASK;
    segl_p0  = {1'b0, glyph(split_p0[3:0])} ^ BUS_MASK;
  end

  logic [6:0] hex_p1;
  logic [7:0] segh_p1;
  logic [7:0] segl_p1;

  // Stage p1: output register; reset drives the blank pattern in the
  // selected polarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_p1  <= GLYPH_BLANK ^ HEX_MASK;
      segh_p1 <= 8'h00 ^ BUS_MASK;
      segl_p1 <= 8'h00 ^ BUS_MASK;
    end else begin
      hex_p1  <= hex_p0;
      segh_p1 <= segh_p0;
      segl_p1 <= segl_p0;
    end
  end

  assign {g, f, e, d, c, b, a} = hex_p1;
  assign segh = segh_p1;
  assign segl = segl_p1;

endmodule

// File: tb/tb_sevenseg_hexdec_decoder.sv
// Randomized bench for sevenseg_hexdec_decoder: three parameter variants share
// one stimulus stream and are checked against a table-driven reference model.
module tb_sevenseg_hexdec_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;

  logic a0, b0, c0, d0, e0, f0, g0;
  logic a1, b1, c1, d1, e1, f1, g1;
  logic a2, b2, c2, d2, e2, f2, g2;
  logic [7:0] segh0, segl0, segh1, segl1, segh2, segl2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sevenseg_hexdec_decoder #(.BLANK_LEADING_ZERO(1), .ACTIVE_LOW(0)) dut_def (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0),
    .segh(segh0), .segl(segl0));

  sevenseg_hexdec_decoder #(.BLANK_LEADING_ZERO(0), .ACTIVE_LOW(0)) dut_lz (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1),
    .segh(segh1), .segl(segl1));

  sevenseg_hexdec_decoder #(.BLANK_LEADING_ZERO(1), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2), .g(g2),
    .segh(segh2), .segl(segl2));

  // Reference glyph table, indexed by digit value.
  logic [6:0] ref_glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: expected {hex7, segh8, segl8} for the value presented before the edge.
  function automatic logic [22:0] model(input int v, input bit r, input bit blz, input bit al);
    logic [6:0] hx;
    logic [7:0] sh, sl;
    int tens, units;
    if (r) begin
      hx = 7'h00; sh = 8'h00; sl = 8'h00;
    end else begin
      tens  = v / 10;
      units = v % 10;
      hx = ref_glyph[v];
      sl = {1'b0, ref_glyph[units]};
      if (tens == 1)      sh = 8'h06;
      else if (blz)       sh = 8'h00;
      else                sh = 8'h3F;
    end
    if (al) begin
      hx = ~hx; sh = ~sh; sl = ~sl;
    end
    return {hx, sh, sl};
  endfunction

  task automatic check_all(input string tag, input int v, input bit r);
    logic [22:0] e;
    e = model(v, r, 1'b1, 1'b0);
    chk({tag, ".def.hex"},  {25'd0, g0, f0, e0, d0, c0, b0, a0}, {25'd0, e[22:16]});
    chk({tag, ".def.segh"}, {24'd0, segh0}, {24'd0, e[15:8]});
    chk({tag, ".def.segl"}, {24'd0, segl0}, {24'd0, e[7:0]});
    e = model(v, r, 1'b0, 1'b0);
    chk({tag, ".lz.hex"},   {25'd0, g1, f1, e1, d1, c1, b1, a1}, {25'd0, e[22:16]});
    chk({tag, ".lz.segh"},  {24'd0, segh1}, {24'd0, e[15:8]});
    chk({tag, ".lz.segl"},  {24'd0, segl1}, {24'd0, e[7:0]});
    e = model(v, r, 1'b1, 1'b1);
    chk({tag, ".al.hex"},   {25'd0, g2, f2, e2, d2, c2, b2, a2}, {25'd0, e[22:16]});
    chk({tag, ".al.segh"},  {24'd0, segh2}, {24'd0, e[15:8]});
    chk({tag, ".al.segl"},  {24'd0, segl2}, {24'd0, e[7:0]});
  endtask

  // Present v and r, clock once, then check one time unit after the edge.
  task automatic step(input string tag, input int v, input bit r);
    logic [3:0] vb;
    vb = v[3:0];
    {A, B, C, D} = vb;
    rst = r;
    @(posedge clk);
    #1;
    check_all(tag, v, r);
  endtask

  initial begin
    int v;
    bit r;
    // Reset held for two edges with v = 8.
    step("rst0", 8, 1'b1);
    step("rst1", 8, 1'b1);
    chk("rst.segl_raw", {24'd0, segl0}, 32'h00);
    chk("rst.al_segh_raw", {24'd0, segh2}, 32'hFF);
    step("rel", 8, 1'b0);
    chk("rel.hex_raw", {25'd0, g0, f0, e0, d0, c0, b0, a0}, 32'h7F);
    // Binary sweep with spot checks at the documented boundaries.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("sweep%0d", i), i, 1'b0);
      if (i == 1)  chk("al.v1.hex_raw", {25'd0, g2, f2, e2, d2, c2, b2, a2}, 32'h79);
      if (i == 1)  chk("al.v1.segl_raw", {24'd0, segl2}, 32'hF9);
      if (i == 3)  chk("lz.v3.segh_raw", {24'd0, segh1}, 32'h3F);
      if (i == 9)  chk("v9.segl_raw", {24'd0, segl0}, 32'h6F);
      if (i == 10) chk("v10.segh_raw", {24'd0, segh0}, 32'h06);
      if (i == 11) chk("v11.hex_raw", {25'd0, g0, f0, e0, d0, c0, b0, a0}, 32'h7C);
      if (i == 12) chk("lz.v12.segl_raw", {24'd0, segl1}, 32'h5B);
      if (i == 15) chk("v15.segl_raw", {24'd0, segl0}, 32'h6D);
    end
    // Mid-stream reset at v = 5, then resume with no stale value.
    step("mid4", 4, 1'b0);
    step("mid5", 5, 1'b1);
    step("mid6", 6, 1'b0);
    chk("mid6.hex_raw", {25'd0, g0, f0, e0, d0, c0, b0, a0}, 32'h7D);
    // Randomized stream with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      v = int'($urandom_range(0, 15));
      r = ($urandom_range(0, 15) == 0);
      step("rand", v, r);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
